// File: rtl/phy_tx_scheduler_if.sv
// phy_tx_scheduler_if: request, packet, symbol and status signals between the scheduler and its environment.
interface phy_tx_scheduler_if #(
    parameter int NUM_VC = 2,
    parameter int FLIT_W = 64,
    parameter int VC_W   = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
);
    logic              ack_req;
    logic [NUM_VC-1:0] grant_req;
    logic              pkt_valid;
    logic [7:0]        pkt_len;
    logic [FLIT_W-1:0] flit_in;
    logic              flit_pop;
    logic              sym_start;
    logic [2:0]        sym_sel;
    logic [VC_W-1:0]   sym_vc;
    logic [FLIT_W-1:0] sym_flit;
    logic              sym_done;
    logic              ack_full;
    logic [NUM_VC-1:0] grant_full;
    logic              busy;

    modport slave (
        input  ack_req, grant_req, pkt_valid, pkt_len, flit_in, sym_done,
        output flit_pop, sym_start, sym_sel, sym_vc, sym_flit, ack_full, grant_full, busy
    );
    modport master (
        output ack_req, grant_req, pkt_valid, pkt_len, flit_in, sym_done,
        input  flit_pop, sym_start, sym_sel, sym_vc, sym_flit, ack_full, grant_full, busy
    );
endinterface

// File: rtl/phy_tx_scheduler.sv
// phy_tx_scheduler: issues ACK, round-robin GRANT and packet flit symbols to a serializer, one at a time.
// Macro PHY_TX_CTRL_INTERLEAVE_EN lets pending ACK/GRANT preempt between flits of an in-progress packet.
module phy_tx_scheduler #(
    parameter int NUM_VC = 2,
    parameter int CNT_W  = 4,
    parameter int FLIT_W = 64
) (
    input  logic             CLK,
    input  logic             RST,
    phy_tx_scheduler_if.slave bus
);
    localparam int VC_W = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
    localparam logic [CNT_W-1:0] CMAX = '1;
    localparam logic [1:0] S_IDLE = 2'd0, S_ISSUE = 2'd1, S_WAIT = 2'd2;
    localparam logic [2:0] K_DATA = 3'd0, K_START = 3'd1, K_END = 3'd2, K_ACK = 3'd3, K_GRANT = 3'd4;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  ack_cnt_q, ack_cnt_d;
    logic [CNT_W-1:0]  gnt_cnt_q [NUM_VC];
    logic [CNT_W-1:0]  gnt_cnt_d [NUM_VC];
    logic [VC_W-1:0]   rr_q, rr_d;
    logic [7:0]        rem_q, rem_d;
    logic              pkt_act_q, pkt_act_d;
    logic [2:0]        sel_q, sel_d;
    logic [VC_W-1:0]   vc_q, vc_d;
    logic [FLIT_W-1:0] flit_q, flit_d;

    logic              issue, ack_dec, ack_inc, ctrl_ok, ack_el, gnt_el, pkt_el, gnt_any;
    logic [NUM_VC-1:0] gnt_nz, gnt_dec, gnt_inc;
    logic [VC_W-1:0]   gnt_vc, cand;
    logic [7:0]        rlen;

    assign issue   = state_q == S_ISSUE;
    assign ack_dec = issue && sel_q == K_ACK;
    assign ack_inc = bus.ack_req && (ack_cnt_q != CMAX || ack_dec);
    assign ack_cnt_d = (ack_inc && !ack_dec) ? ack_cnt_q + 1'b1 :
                       (!ack_inc && ack_dec) ? ack_cnt_q - 1'b1 : ack_cnt_q;

    always_comb begin
        gnt_dec = '0;
        gnt_inc = '0;
        gnt_nz  = '0;
        for (int i = 0; i < NUM_VC; i++) begin
            gnt_nz[i]    = gnt_cnt_q[i] != '0;
            gnt_dec[i]   = issue && sel_q == K_GRANT && vc_q == VC_W'(i);
            gnt_inc[i]   = bus.grant_req[i] && (gnt_cnt_q[i] != CMAX || gnt_dec[i]);
            gnt_cnt_d[i] = (gnt_inc[i] && !gnt_dec[i]) ? gnt_cnt_q[i] + 1'b1 :
                           (!gnt_inc[i] && gnt_dec[i]) ? gnt_cnt_q[i] - 1'b1 : gnt_cnt_q[i];
        end
    end

    // Scan downward from the farthest offset so the VC nearest the pointer wins.
    always_comb begin
        gnt_any = 1'b0;
        gnt_vc  = '0;
        cand    = '0;
        for (int k = NUM_VC - 1; k >= 0; k--) begin
            cand = VC_W'((32'(rr_q) + 32'(k)) % NUM_VC);
            if (gnt_nz[cand]) begin
                gnt_any = 1'b1;
                gnt_vc  = cand;
            end
        end
    end

`ifdef PHY_TX_CTRL_INTERLEAVE_EN
    assign ctrl_ok = 1'b1;
`else
    assign ctrl_ok = !pkt_act_q;
`endif
    assign ack_el = ctrl_ok && ack_cnt_q != '0;
    assign gnt_el = ctrl_ok && gnt_any;
    assign pkt_el = pkt_act_q || bus.pkt_valid;
    assign rlen   = pkt_act_q ? rem_q : (bus.pkt_len == 8'd0 ? 8'd1 : bus.pkt_len);
    assign rr_d   = (issue && sel_q == K_GRANT) ? (vc_q == VC_W'(NUM_VC - 1) ? '0 : vc_q + 1'b1) : rr_q;

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        vc_d      = vc_q;
        flit_d    = flit_q;
        rem_d     = rem_q;
        pkt_act_d = pkt_act_q;
        if (state_q == S_IDLE && (ack_el || gnt_el || pkt_el)) begin
            state_d = S_ISSUE;
            sel_d   = ack_el ? K_ACK : gnt_el ? K_GRANT : rlen == 8'd1 ? K_END : pkt_act_q ? K_DATA : K_START;
            vc_d    = (!ack_el && gnt_el) ? gnt_vc : '0;
            flit_d  = (ack_el || gnt_el) ? '0 : bus.flit_in;
            if (!ack_el && !gnt_el) begin
                rem_d     = rlen - 8'd1;
                pkt_act_d = rlen != 8'd1;
            end
        end else if (state_q == S_ISSUE) begin
            state_d = S_WAIT;
        end else if (state_q == S_WAIT && bus.sym_done) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= S_IDLE;
            ack_cnt_q <= '0;
            gnt_cnt_q <= '{default: '0};
            rr_q      <= '0;
            rem_q     <= '0;
            pkt_act_q <= 1'b0;
            sel_q     <= '0;
            vc_q      <= '0;
            flit_q    <= '0;
        end else begin
            state_q   <= state_d;
            ack_cnt_q <= ack_cnt_d;
            gnt_cnt_q <= gnt_cnt_d;
            rr_q      <= rr_d;
            rem_q     <= rem_d;
            pkt_act_q <= pkt_act_d;
            sel_q     <= sel_d;
            vc_q      <= vc_d;
            flit_q    <= flit_d;
        end
    end

    always_comb begin
        bus.grant_full = '0;
        for (int i = 0; i < NUM_VC; i++) bus.grant_full[i] = gnt_cnt_q[i] == CMAX;
    end

    assign bus.sym_start = issue;
    assign bus.flit_pop  = issue && sel_q <= K_END;
    assign bus.sym_sel   = sel_q;
    assign bus.sym_vc    = vc_q;
    assign bus.sym_flit  = flit_q;
    assign bus.ack_full  = ack_cnt_q == CMAX;
    assign bus.busy      = pkt_act_q || state_q != S_IDLE;
endmodule

// File: tb/tb_phy_tx_scheduler.sv
// tb_phy_tx_scheduler: directed stimulus with an expected-symbol queue checked by an independent monitor.
module tb_phy_tx_scheduler;
    typedef logic [68:0] sym_t;

    logic CLK, RST, auto_done;
    int   cyc, nstart, nack, last_cyc, ntests, nfail, pkt_cmd, pkt_seen, fi;
    sym_t expq[$];

    phy_tx_scheduler_if #(.NUM_VC(2), .FLIT_W(64)) bus ();
    phy_tx_scheduler #(.NUM_VC(2), .CNT_W(4), .FLIT_W(64)) dut (.CLK(CLK), .RST(RST), .bus(bus));

    function automatic logic [63:0] flitv(input int i);
        return 64'hA5A5_0000_0000_0000 + 64'(i) + 64'd1;
    endfunction

    assign bus.pkt_valid = pkt_cmd != pkt_seen;
    assign bus.flit_in   = flitv(fi);
    assign bus.sym_done  = auto_done;

    initial begin
        CLK = 0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge CLK);
            cyc++;
        end
    end

    // Upstream source: advance on each pop; the first pop retires pkt_valid.
    initial begin
        fi = 0;
        pkt_seen = 0;
        forever begin
            @(posedge CLK);
            if (!RST && bus.flit_pop) begin
                if (bus.pkt_valid) pkt_seen++;
                fi++;
            end
        end
    end

    initial begin
        sym_t got, want;
        forever begin
            @(negedge CLK);
            if (!RST && bus.sym_start) begin
                got = {bus.sym_sel, bus.sym_vc, bus.sym_flit, bus.flit_pop};
                nstart++;
                last_cyc = cyc;
                if (bus.sym_sel == 3'd3) nack++;
                ntests++;
                if (expq.size() == 0) begin
                    nfail++;
                    $display("FAIL unexpected_sym got=%h want=none", got);
                end else begin
                    want = expq.pop_front();
                    if (got !== want) begin
                        nfail++;
                        $display("FAIL sym%0d got=%h want=%h", nstart, got, want);
                    end
                end
            end else if (!RST && bus.flit_pop) begin
                ntests++;
                nfail++;
                $display("FAIL stray_flit_pop got=1 want=0");
            end
        end
    end

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
        ntests++;
        if (got !== want) begin
            nfail++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic wait_starts(input int n);
        int b = 0;
        while (nstart < n && b < 200) begin
            tick();
            b++;
        end
        chk("wait_starts", 128'(nstart >= n), 128'd1);
    endtask

    task automatic drain();
        int b = 0;
        while ((expq.size() != 0 || bus.busy) && b < 500) begin
            tick();
            b++;
        end
        chk("drain", 128'(expq.size()), 128'd0);
        tick(3);
    endtask

    function automatic sym_t ack_s();
        return {3'd3, 1'b0, 64'd0, 1'b0};
    endfunction
    function automatic sym_t gnt_s(input logic vc);
        return {3'd4, vc, 64'd0, 1'b0};
    endfunction
    function automatic sym_t flit_s(input logic [2:0] sel, input int i);
        return {sel, 1'b0, flitv(i), 1'b1};
    endfunction

    initial begin
        int c0, n0, nack0, base;
        RST = 1; auto_done = 1; pkt_cmd = 0;
        nstart = 0; nack = 0; last_cyc = 0; ntests = 0; nfail = 0;
        bus.ack_req = 0; bus.grant_req = '0; bus.pkt_len = '0;
        tick(3);
        chk("reset_outputs", 128'({bus.sym_start, bus.sym_sel, bus.sym_vc, bus.sym_flit, bus.flit_pop,
                                   bus.ack_full, bus.grant_full, bus.busy}), 128'd0);
        RST = 0;
        tick();

        // single ACK: two cycles from request to sym_start, counter empties
        expq.push_back(ack_s());
        c0 = cyc;
        bus.ack_req = 1;
        tick();
        bus.ack_req = 0;
        wait_starts(1);
        chk("ack_latency", 128'(last_cyc - c0), 128'd2);
        tick(4);
        chk("ack_cnt_zero", 128'(dut.ack_cnt_q), 128'd0);

        // round-robin grants from pointer 0, then from pointer 1
        expq.push_back(gnt_s(1'b0));
        expq.push_back(gnt_s(1'b1));
        bus.grant_req = 2'b11;
        tick();
        bus.grant_req = 2'b00;
        drain();
        expq.push_back(gnt_s(1'b0));
        bus.grant_req = 2'b01;
        tick();
        bus.grant_req = 2'b00;
        drain();
        expq.push_back(gnt_s(1'b1));
        expq.push_back(gnt_s(1'b0));
        bus.grant_req = 2'b11;
        tick();
        bus.grant_req = 2'b00;
        drain();

        // three-flit packet with an ACK requested while B is on the wire
        base = fi;
        expq.push_back(flit_s(3'd1, base));
        expq.push_back(flit_s(3'd0, base + 1));
`ifdef PHY_TX_CTRL_INTERLEAVE_EN
        expq.push_back(ack_s());
        expq.push_back(flit_s(3'd2, base + 2));
`else
        expq.push_back(flit_s(3'd2, base + 2));
        expq.push_back(ack_s());
`endif
        n0 = nstart;
        bus.pkt_len = 8'd3;
        pkt_cmd++;
        wait_starts(n0 + 2);
        bus.ack_req = 1;
        tick();
        bus.ack_req = 0;
        drain();
        chk("pkt_pops", 128'(fi - base), 128'd3);

        // ACK saturation while the serializer is stalled on a grant
        auto_done = 0;
        expq.push_back(gnt_s(1'b0));
        n0 = nstart;
        bus.grant_req = 2'b01;
        tick();
        bus.grant_req = 2'b00;
        wait_starts(n0 + 1);
        for (int k = 1; k <= 16; k++) begin
            bus.ack_req = 1;
            tick();
            if (k == 14) chk("ack_full_after14", 128'(bus.ack_full), 128'd0);
            if (k == 15) chk("ack_full_after15", 128'(bus.ack_full), 128'd1);
            if (k == 16) chk("ack_full_after16", 128'(bus.ack_full), 128'd1);
        end
        bus.ack_req = 0;
        chk("ack_cnt_sat", 128'(dut.ack_cnt_q), 128'd15);
        for (int k = 0; k < 15; k++) expq.push_back(ack_s());
        nack0 = nack;
        auto_done = 1;
        drain();
        chk("ack_issued", 128'(nack - nack0), 128'd15);
        chk("ack_full_clear", 128'(bus.ack_full), 128'd0);

        // asynchronous reset in WAIT mid-packet, then a fresh packet
        auto_done = 0;
        base = fi;
        expq.push_back(flit_s(3'd1, base));
        n0 = nstart;
        bus.pkt_len = 8'd3;
        pkt_cmd++;
        wait_starts(n0 + 1);
        #3 RST = 1;
        #1 chk("rst_outputs", 128'({bus.sym_start, bus.sym_sel, bus.sym_vc, bus.sym_flit, bus.flit_pop,
                                     bus.ack_full, bus.grant_full, bus.busy}), 128'd0);
        tick(2);
        RST = 0;
        auto_done = 1;
        tick();
        base = fi;
        expq.push_back(flit_s(3'd1, base));
        expq.push_back(flit_s(3'd2, base + 1));
        bus.pkt_len = 8'd2;
        pkt_cmd++;
        drain();
        chk("restart_pops", 128'(fi - base), 128'd2);
        chk("idle_busy", 128'(bus.busy), 128'd0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end
endmodule
